// File: rtl/caf_peak_select_pkg.sv
// Shared CAF definitions: state encoding, width defaults common with argmax,
// and the bin counter width helper.
package caf_peak_select_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } caf_state_t;

    localparam int CAF_NUM_BINS   = 8;
    localparam int CAF_INDEX_BITS = 4;
    localparam int CAF_MAX_BITS   = 4;

    // Bin counter must hold 0..n-1; never narrower than one bit.
    function automatic int caf_bin_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/caf_peak_select_peak_cmp_reg.sv
// Running peak register: load-first, then replace only on strictly greater magnitude.
// Latency: win_* is combinational (value held after this edge), best updates one edge later.
// Backpressure: none; load_en qualifies every update.
module caf_peak_select_peak_cmp_reg
    import caf_peak_select_pkg::*;
#(
    parameter int max_bits   = CAF_MAX_BITS,
    parameter int index_bits = CAF_INDEX_BITS,
    parameter int bin_bits   = caf_bin_bits(CAF_NUM_BINS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  load_first,
    input  logic [max_bits-1:0]   cand_max,
    input  logic [index_bits-1:0] cand_index,
    input  logic [bin_bits-1:0]   cand_bin,
    output logic [max_bits-1:0]   win_max,
    output logic [index_bits-1:0] win_index,
    output logic [bin_bits-1:0]   win_bin
);

    logic [max_bits-1:0]   best_max;
    logic [index_bits-1:0] best_index;
    logic [bin_bits-1:0]   best_bin;
    logic                  take;

    // Equal magnitudes never replace, so ties resolve to the earlier bin.
    always_comb begin
        take      = load_first | (cand_max > best_max);
        win_max   = take ? cand_max   : best_max;
        win_index = take ? cand_index : best_index;
        win_bin   = take ? cand_bin   : best_bin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_max   <= '0;
            best_index <= '0;
            best_bin   <= '0;
        end else if (load_en) begin
            best_max   <= win_max;
            best_index <= win_index;
            best_bin   <= win_bin;
        end
    end

endmodule

// File: rtl/caf_peak_select.sv
// Global peak across num_bins per-bin argmax results; one result per CAF frame.
// Latency: result valid the cycle after the last bin is accepted.
// Backpressure: input ready drops while a result waits; one bubble per frame on handoff.
module caf_peak_select
    import caf_peak_select_pkg::*;
#(
    parameter int num_bins   = CAF_NUM_BINS,
    parameter int bin_bits   = caf_bin_bits(num_bins),
    parameter int index_bits = CAF_INDEX_BITS,
    parameter int max_bits   = CAF_MAX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_axis_tvalid,
    input  logic [max_bits-1:0]   in_max,
    input  logic [index_bits-1:0] in_index,
    output logic                  s_axis_tready,
    input  logic                  m_axis_tready,
    output logic [max_bits-1:0]   out_max,
    output logic [index_bits-1:0] out_index,
    output logic [bin_bits-1:0]   out_bin,
    output logic                  s_axis_tvalid
);

    localparam logic [bin_bits-1:0] LAST_BIN = bin_bits'(num_bins - 1);

    caf_state_t            state;
    caf_state_t            state_nxt;
    logic [bin_bits-1:0]   bin_cnt;
    logic                  accept;
    logic                  last_accept;
    logic [max_bits-1:0]   win_max;
    logic [index_bits-1:0] win_index;
    logic [bin_bits-1:0]   win_bin;

    assign accept      = m_axis_tvalid & s_axis_tready;
    assign last_accept = accept & (bin_cnt == LAST_BIN);

    caf_peak_select_peak_cmp_reg #(
        .max_bits   (max_bits),
        .index_bits (index_bits),
        .bin_bits   (bin_bits)
    ) u_bin_peak (
        .clk        (clk),
        .rst        (rst),
        .load_en    (accept),
        .load_first (bin_cnt == '0),
        .cand_max   (in_max),
        .cand_index (in_index),
        .cand_bin   (bin_cnt),
        .win_max    (win_max),
        .win_index  (win_index),
        .win_bin    (win_bin)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_accept)   state_nxt = EMIT;
            EMIT:    if (m_axis_tready) state_nxt = COLLECT;
            default:                    state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            bin_cnt       <= '0;
            s_axis_tready <= 1'b1;
            s_axis_tvalid <= 1'b0;
            out_max       <= '0;
            out_index     <= '0;
            out_bin       <= '0;
        end else begin
            state         <= state_nxt;
            s_axis_tready <= (state_nxt == COLLECT);
            s_axis_tvalid <= (state_nxt == EMIT);
            if (accept) begin
                bin_cnt <= last_accept ? '0 : bin_cnt + bin_bits'(1);
            end
            // Winner includes the final sample's compare on this same edge.
            if (last_accept) begin
                out_max   <= win_max;
                out_index <= win_index;
                out_bin   <= win_bin;
            end
        end
    end

endmodule

// File: tb/tb_caf_peak_select.sv
// Randomized and directed frames checked every cycle against a frame-level peak model.
module tb_caf_peak_select;

    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_axis_tvalid = 1'b0;
    logic [3:0] in_max = '0;
    logic [3:0] in_index = '0;
    logic       s_axis_tready;
    logic       m_axis_tready = 1'b1;
    logic [3:0] out_max;
    logic [3:0] out_index;
    logic [2:0] out_bin;
    logic       s_axis_tvalid;

    int   n_tests = 0;
    int   n_fail = 0;
    int   ds_mode = 0;
    logic ds_fixed = 1'b1;
    int   fm [NB];
    int   fi [NB];

    caf_peak_select dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tvalid (m_axis_tvalid),
        .in_max        (in_max),
        .in_index      (in_index),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .out_max       (out_max),
        .out_index     (out_index),
        .out_bin       (out_bin),
        .s_axis_tvalid (s_axis_tvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: collect a frame, report the first bin holding the largest magnitude.
    int  q_max[$];
    int  q_idx[$];
    bit  pending = 1'b0;
    int  exp_max = 0;
    int  exp_idx = 0;
    int  exp_bin = 0;

    always @(posedge clk) begin
        int pk;
        int wb;
        if (rst) begin
            pending = 1'b0;
            q_max.delete();
            q_idx.delete();
            exp_max = 0;
            exp_idx = 0;
            exp_bin = 0;
        end else if (pending) begin
            if (m_axis_tready) pending = 1'b0;
        end else if (m_axis_tvalid) begin
            q_max.push_back(int'(in_max));
            q_idx.push_back(int'(in_index));
            if (q_max.size() == NB) begin
                pk = -1;
                foreach (q_max[k]) if (q_max[k] > pk) pk = q_max[k];
                wb = -1;
                foreach (q_max[k]) if (wb < 0 && q_max[k] == pk) wb = k;
                exp_max = pk;
                exp_idx = q_idx[wb];
                exp_bin = wb;
                pending = 1'b1;
                q_max.delete();
                q_idx.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_tvalid", int'(s_axis_tvalid), int'(pending));
            chk("m_tready", int'(s_axis_tready), int'(!pending));
            chk("m_max",    int'(out_max),   exp_max);
            chk("m_index",  int'(out_index), exp_idx);
            chk("m_bin",    int'(out_bin),   exp_bin);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        m_axis_tready = (ds_mode == 1) ? 1'($urandom_range(0, 1)) : ds_fixed;
    end

    // Present one sample; while blocked, show changing data that must not be taken.
    task automatic drive_sample(input int m, input int i);
        int guard;
        guard = 0;
        @(negedge clk);
        m_axis_tvalid = 1'b1;
        in_max   = 4'(m);
        in_index = 4'(i);
        while (!s_axis_tready && guard < 200) begin
            in_max   = 4'($urandom);
            in_index = 4'($urandom);
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout: s_axis_tready stuck low, required high");
        end
        in_max   = 4'(m);
        in_index = 4'(i);
    endtask

    task automatic send_frame(input int gap);
        for (int b = 0; b < NB; b++) begin
            if (gap == 1) begin
                @(negedge clk);
                m_axis_tvalid = 1'b0;
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    m_axis_tvalid = 1'b0;
                end
            end
            drive_sample(fm[b], fi[b]);
        end
    endtask

    task automatic end_check(input string nm, input int m, input int i, input int b);
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        chk({nm, "_vld"},   int'(s_axis_tvalid), 1);
        chk({nm, "_rdy"},   int'(s_axis_tready), 0);
        chk({nm, "_max"},   int'(out_max),   m);
        chk({nm, "_index"}, int'(out_index), i);
        chk({nm, "_bin"},   int'(out_bin),   b);
    endtask

    task automatic load_frame(input int sel);
        int base [NB];
        base = '{2, 5, 3, 9, 1, 9, 4, 0};
        for (int b = 0; b < NB; b++) begin
            case (sel)
                0: begin fm[b] = base[b]; fi[b] = b + 1; end
                1: begin fm[b] = 7; fi[b] = b + 2; end
                2: begin fm[b] = (b == NB - 1) ? 15 : 1; fi[b] = (b == NB - 1) ? 11 : b; end
                3: begin fm[b] = (b == 2 || b == 4) ? 8 : 3 - (b % 4); fi[b] = 15 - b; end
                default: begin fm[b] = b; fi[b] = b; end
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", int'(s_axis_tready), 1);
        chk("rst_tvalid", int'(s_axis_tvalid), 0);
        chk("rst_max",    int'(out_max), 0);
        chk("rst_bin",    int'(out_bin), 0);

        // Three high samples, then reset: they must not leak into the next frame.
        for (int b = 0; b < 3; b++) drive_sample(15, 14);
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        load_frame(0);
        send_frame(0);
        end_check("b2b", 9, 4, 3);
        @(negedge clk);
        chk("bubble_rdy", int'(s_axis_tready), 1);
        chk("bubble_vld", int'(s_axis_tvalid), 0);

        load_frame(1);
        send_frame(0);
        end_check("equal", 7, 2, 0);

        load_frame(2);
        send_frame(0);
        end_check("lastbin", 15, 11, 7);
        ds_fixed = 1'b0;

        load_frame(3);
        send_frame(0);
        end_check("bp", 8, 13, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m_axis_tvalid = 1'b1;
            in_max   = 4'($urandom);
            in_index = 4'($urandom);
            chk("bp_hold_vld", int'(s_axis_tvalid), 1);
            chk("bp_hold_rdy", int'(s_axis_tready), 0);
            chk("bp_hold_max", int'(out_max), 8);
            chk("bp_hold_bin", int'(out_bin), 2);
        end
        ds_fixed = 1'b1;
        load_frame(4);
        send_frame(0);
        end_check("after_bp", 7, 7, 7);

        load_frame(0);
        send_frame(1);
        end_check("gapped", 9, 4, 3);

        ds_mode = 1;
        for (int f = 0; f < 30; f++) begin
            for (int b = 0; b < NB; b++) begin
                fm[b] = $urandom_range(0, 15);
                fi[b] = $urandom_range(0, 15);
            end
            send_frame(2);
        end
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        ds_mode = 0;
        ds_fixed = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
